mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 3-input select mux: drives its select lines S2..S0 and steps through data channels 0..NUM_CH-1.
- Holds each channel for DWELL cycles, then samples the mux output bit.
- Presents the captured channel vector with a start/busy/done handshake to the consuming logic.
- Supports single-shot and continuous scan modes, plus a synchronous abort.

Parameters:
- NUM_CH, 3: number of mux channels scanned, legal range 1..7. Channel k drives select code k.
- DWELL, 4: cycles each select code is held before sampling, legal range 1..255.
- CNT_W, 8: dwell counter width. It must satisfy 2^CNT_W > DWELL-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- continuous  input  1  when 1 at scan completion, the next scan starts immediately.
- abort  input  1  synchronous cancel of a scan in progress.
- mux_out  input  1  output of the downstream select mux.
- S0  output  1  select bit 0 (LSB) to the mux.
- S1  output  1  select bit 1 to the mux.
- S2  output  1  select bit 2 (MSB) to the mux.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when sample is updated.
- sample  output  NUM_CH  captured mux_out per channel; bit k holds channel k.

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - state=IDLE, {S2,S1,S0}=000, busy=0, done=0, sample=0.
  - Internal channel index, dwell counter and shadow register all cleared.
- States: IDLE, SCAN.
  - done is a registered flag set on the completion edge; no separate state is needed.
- IDLE:
  - Selects are held at 000.
  - On an edge with start=1 and abort=0: state becomes SCAN, busy=1, ch=0, cnt=0, shadow=0.
- SCAN:
  - {S2,S1,S0} = ch, driven from registers so the selects are glitch-free.
  - Each edge increments cnt.
  - On the edge where cnt==DWELL-1: shadow[ch] <= mux_out and cnt <= 0.
    - If ch<NUM_CH-1: ch <= ch+1.
    - Otherwise the scan completes: sample <= shadow with bit ch replaced by mux_out, and done <= 1 for exactly one cycle.
- Completion with continuous=0: state IDLE, busy=0, selects return to 000.
- Completion with continuous=1: stays in SCAN, busy stays 1, ch=0, cnt=0, shadow cleared. The done pulse is still issued.
- Latency: done asserts NUM_CH*DWELL rising edges after the edge that accepted start. Default is 12 cycles.
- mux_out is sampled DWELL cycles after the select change. DWELL=1 samples in the first cycle the code is valid.
- Visibility: sample changes only on the done edge. Partial scans are never visible.
- start while busy: ignored, with no restart and no queuing.
- abort=1 in SCAN: next edge returns to IDLE with busy=0 and selects 000. sample is unchanged and done is not pulsed.
- abort in IDLE: no effect. abort has priority over start and over completion on the same edge.
- Reset mid-scan: all registers are cleared per the reset row, and sample reads 0.
- Channel wrap: ch never exceeds NUM_CH-1. Codes NUM_CH..7 are never driven.
- done and busy relationship:
  - Single-shot: busy falls on the same edge that done rises.
  - Continuous: busy remains high through done.

Test Plan:
- Reset, then start for 1 cycle with mux_out tied to the channel code pattern D0=1, D1=0, D2=1 (so mux_out=1 when sel=0 or 2). Default parameters. Required: busy=1 for 12 cycles, selects hold 000, 001, 010 for 4 cycles each, done pulses once at edge 12, sample=3'b101, selects return to 000.
- DWELL=1, NUM_CH=3, mux_out=1 constant -> done at edge 3 after start, sample=3'b111.
- Pulse start again at cycles 2 and 7 during a scan -> exactly one done at edge 12, with no second scan.
- abort at cycle 6 of a scan, with a prior sample of 3'b101 -> busy=0 next edge, selects 000, no done, sample remains 3'b101.
- continuous=1 with mux_out toggling pattern 010 then 110 -> done pulses at edges 12 and 24, busy stays high, sample=3'b010 after the first pulse and 3'b110 after the second.
- Assert reset asynchronously mid-cycle at cycle 5 of a scan -> outputs immediately 0 and selects 000. After release, start gives a normal 12-cycle scan.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module   : mux_scan_sequencer
// Brief    : Drives 3-bit mux selects, dwells per channel, captures mux_out
//            into a per-channel vector with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer #(
  parameter int NUM_CH = 3,
  parameter int DWELL  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              mux_out,
  output logic              S0,
  output logic              S1,
  output logic              S2,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);
  localparam logic [2:0]       c_ch_last  = 3'(NUM_CH - 1);

  state_t              r_state;
  logic [2:0]          r_ch;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_CH-1:0]   r_shadow;
  logic [NUM_CH-1:0]   r_sample;
  logic                r_busy;
  logic                r_done;

  logic                w_dwell_end;
  logic [NUM_CH-1:0]   w_shadow_next;

  assign w_dwell_end = (r_cnt == c_cnt_last);

  // Shadow with the current channel's bit replaced by the live mux output.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == 3'(k)) begin
        w_shadow_next[k] = mux_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sample <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state  <= SCAN;
            r_busy   <= 1'b1;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
          end else if (w_dwell_end) begin
            r_cnt    <= '0;
            r_shadow <= w_shadow_next;
            if (r_ch < c_ch_last) begin
              r_ch <= r_ch + 3'd1;
            end else begin
              // Last channel: publish the whole vector at once, then rewind.
              r_sample <= w_shadow_next;
              r_done   <= 1'b1;
              r_ch     <= '0;
              r_shadow <= '0;
              if (!continuous) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Selects come straight from the channel register, so they never glitch.
  assign {S2, S1, S0} = r_ch;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample       = r_sample;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// Module   : tb_mux_scan_sequencer
// Brief    : Directed bench with a scoreboard of expected sample vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       abort = 1'b0;
  logic       mux_out;
  logic       S0, S1, S2, busy, done;
  logic [2:0] sample;
  logic [7:0] pat = 8'h00;

  logic       start1 = 1'b0;
  logic       S0_1, S1_1, S2_1, busy1, done1;
  logic [2:0] sample1;

  int checks = 0;
  int failures = 0;
  int n;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  // Behavioural data mux: channel k presents pat[k].
  assign mux_out = pat[{S2, S1, S0}];

  mux_scan_sequencer #(.NUM_CH(3), .DWELL(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .mux_out(mux_out), .S0(S0), .S1(S1), .S2(S2),
    .busy(busy), .done(done), .sample(sample)
  );

  mux_scan_sequencer #(.NUM_CH(3), .DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .continuous(1'b0),
    .abort(1'b0), .mux_out(1'b1), .S0(S0_1), .S1(S1_1), .S2(S2_1),
    .busy(busy1), .done(done1), .sample(sample1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("sb0_expected_done", 8'(q0.size() != 0), 8'd1);
      if (q0.size() != 0) chk("sb0_sample", 8'(sample), 8'(q0.pop_front()));
    end
    if (done1 === 1'b1) begin
      chk("sb1_expected_done", 8'(q1.size() != 0), 8'd1);
      if (q1.size() != 0) chk("sb1_sample", 8'(sample1), 8'(q1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_sample", 8'(sample), 8'd0);
    chk("rst_sel", 8'({S2, S1, S0}), 8'd0);
    chk("rst_busy1", 8'(busy1), 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-shot scan, D0=1 D1=0 D2=1
    pat = 8'b0000_0101;
    q0.push_back(3'b101);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("t1_busy", 8'(busy), 8'd1);
      chk("t1_sel", 8'({S2, S1, S0}), 8'(i / 4));
      chk("t1_no_done", 8'(done), 8'd0);
      @(negedge clk);
    end
    chk("t1_done", 8'(done), 8'd1);
    chk("t1_busy_fall", 8'(busy), 8'd0);
    chk("t1_sel_home", 8'({S2, S1, S0}), 8'd0);
    chk("t1_sample", 8'(sample), 8'b101);
    @(negedge clk);
    chk("t1_done_pulse", 8'(done), 8'd0);

    // Abort mid-scan: sample must keep 101
    pat = 8'b0000_0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 8'(busy), 8'd0);
    chk("ab_sel", 8'({S2, S1, S0}), 8'd0);
    chk("ab_done", 8'(done), 8'd0);
    chk("ab_sample", 8'(sample), 8'b101);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("ab_quiet_done", 8'(done), 8'd0);
      chk("ab_quiet_busy", 8'(busy), 8'd0);
    end

    // Start pulses while busy are ignored
    pat = 8'b0000_0011;
    q0.push_back(3'b011);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start = (i == 1 || i == 6);
      chk("rs_no_done", 8'(done), 8'd0);
      chk("rs_busy", 8'(busy), 8'd1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rs_done", 8'(done), 8'd1);
    chk("rs_busy_fall", 8'(busy), 8'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rs_no_rescan", 8'(busy | done), 8'd0);
    end

    // Continuous: two back-to-back scans, then drop continuous
    pat = 8'b0000_0010;
    q0.push_back(3'b010);
    q0.push_back(3'b110);
    continuous = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("ct_busy1", 8'(busy), 8'd1);
      @(negedge clk);
    end
    chk("ct_done1", 8'(done), 8'd1);
    chk("ct_busy_hold", 8'(busy), 8'd1);
    chk("ct_sample1", 8'(sample), 8'b010);
    chk("ct_sel_rewind", 8'({S2, S1, S0}), 8'd0);
    pat = 8'b0000_0110;
    continuous = 1'b0;
    @(negedge clk);
    for (int i = 13; i < 24; i++) begin
      chk("ct_busy2", 8'(busy), 8'd1);
      chk("ct_no_done2", 8'(done), 8'd0);
      @(negedge clk);
    end
    chk("ct_done2", 8'(done), 8'd1);
    chk("ct_busy_end", 8'(busy), 8'd0);
    chk("ct_sample2", 8'(sample), 8'b110);
    @(negedge clk);

    // Asynchronous reset mid-scan, then a clean scan
    pat = 8'b0000_0111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", 8'(busy), 8'd0);
    chk("ar_done", 8'(done), 8'd0);
    chk("ar_sample", 8'(sample), 8'd0);
    chk("ar_sel", 8'({S2, S1, S0}), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    pat = 8'b0000_0101;
    q0.push_back(3'b101);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ar_latency", 8'(n), 8'd12);
    chk("ar_busy_end", 8'(busy), 8'd0);
    @(negedge clk);

    // DWELL=1, mux_out constant 1
    q1.push_back(3'b111);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("d1_latency", 8'(n), 8'd3);
    chk("d1_sample", 8'(sample1), 8'b111);
    chk("d1_busy", 8'(busy1), 8'd0);
    repeat (2) @(negedge clk);

    chk("sb0_drained", 8'(q0.size()), 8'd0);
    chk("sb1_drained", 8'(q1.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
